// File: rtl/order_matcher.sv
// rtl/order_matcher.sv - price-crossing order matcher with per-side resting book
module order_matcher #(
  parameter int DEPTH = 4,
  parameter int PW    = 8,
  parameter int QW    = 8
) (
  input  logic                         slow_clk,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         order_valid,
  input  logic                         order_side,
  input  logic [PW-1:0]                order_price,
  input  logic [QW-1:0]                order_qty,
  output logic                         order_ready,
  output logic                         match_signal,
  output logic [PW-1:0]                match_price,
  output logic [QW-1:0]                match_qty,
  output logic                         reject,
  output logic [$clog2(DEPTH+1)-1:0]   bid_count,
  output logic [$clog2(DEPTH+1)-1:0]   ask_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // resting book, one array set per side
  logic [DEPTH-1:0] bid_valid;
  logic [DEPTH-1:0] ask_valid;
  logic [DEPTH-1:0] bid_valid_nxt;
  logic [DEPTH-1:0] ask_valid_nxt;
  logic [PW-1:0]    bid_price [DEPTH];
  logic [QW-1:0]    bid_qty   [DEPTH];
  logic [PW-1:0]    ask_price [DEPTH];
  logic [QW-1:0]    ask_qty   [DEPTH];

  // in-flight order and best-candidate tracking
  logic             work_side;
  logic [PW-1:0]    work_price;
  logic [QW-1:0]    work_qty;
  logic             best_found;
  logic [IW-1:0]    best_idx;
  logic [PW-1:0]    best_price;
  logic [IW-1:0]    scan_idx;

  logic             accept;
  logic             opp_valid;
  logic [PW-1:0]    opp_price;
  logic             crosses;
  logic             better;
  logic             take;
  logic [QW-1:0]    best_qty;
  logic [QW-1:0]    fill_qty;
  logic [DEPTH-1:0] own_valid;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             decide_live;
  logic             do_fill;
  logic             do_rest;
  logic             do_reject;

  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  assign order_ready = (state == IDLE) && !halt;
  assign accept      = order_valid && order_ready;

  // examine the opposite-side slot under the scan pointer; a buy hits asks, a sell hits bids
  always_comb begin
    opp_valid = work_side ? bid_valid[scan_idx] : ask_valid[scan_idx];
    opp_price = work_side ? bid_price[scan_idx] : ask_price[scan_idx];
    if (work_side) begin
      crosses = opp_valid && (opp_price >= work_price);
      better  = !best_found || (opp_price > best_price);
    end else begin
      crosses = opp_valid && (opp_price <= work_price);
      better  = !best_found || (opp_price < best_price);
    end
    take = (state == SCAN) && crosses && better;
  end

  // resolve the decide outcome: fill against the best slot, rest in the lowest free slot, or reject
  always_comb begin
    best_qty   = work_side ? bid_qty[best_idx] : ask_qty[best_idx];
    fill_qty   = (work_qty < best_qty) ? work_qty : best_qty;
    own_valid  = work_side ? ask_valid : bid_valid;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!own_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    decide_live = (state == DECIDE) && (work_qty != '0);
    do_fill     = decide_live && best_found;
    do_rest     = decide_live && !best_found && free_found;
    do_reject   = decide_live && !best_found && !free_found;
  end

  // next valid bits, so the registered counts move on the same edge as the slots
  always_comb begin
    bid_valid_nxt = bid_valid;
    ask_valid_nxt = ask_valid;
    if (do_fill && (fill_qty == best_qty)) begin
      if (work_side) bid_valid_nxt[best_idx] = 1'b0;
      else           ask_valid_nxt[best_idx] = 1'b0;
    end
    if (do_rest) begin
      if (work_side) ask_valid_nxt[free_idx] = 1'b1;
      else           bid_valid_nxt[free_idx] = 1'b1;
    end
  end

  // state register
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state: scan every slot, decide once, rescan while a filled order still has quantity
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = SCAN;
      SCAN:   if (scan_idx == LAST_IDX) state_nxt = DECIDE;
      DECIDE: begin
        if (do_fill && (work_qty != fill_qty)) state_nxt = SCAN;
        else                                   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // working order, scan pointer and best-candidate registers
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      work_side  <= 1'b0;
      work_price <= '0;
      work_qty   <= '0;
      best_found <= 1'b0;
      best_idx   <= '0;
      best_price <= '0;
      scan_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work_side  <= order_side;
            work_price <= order_price;
            work_qty   <= order_qty;
            best_found <= 1'b0;
            best_idx   <= '0;
            best_price <= '0;
            scan_idx   <= '0;
          end
        end
        SCAN: begin
          if (take) begin
            best_found <= 1'b1;
            best_idx   <= scan_idx;
            best_price <= opp_price;
          end
          scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
        DECIDE: begin
          if (do_fill) begin
            work_qty   <= work_qty - fill_qty;
            best_found <= 1'b0;
            best_idx   <= '0;
            best_price <= '0;
            scan_idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // book valid bits, occupancy counts and the registered fill/reject outputs
  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      bid_valid    <= '0;
      ask_valid    <= '0;
      bid_count    <= '0;
      ask_count    <= '0;
      match_signal <= 1'b0;
      match_price  <= '0;
      match_qty    <= '0;
      reject       <= 1'b0;
    end else begin
      bid_valid    <= bid_valid_nxt;
      ask_valid    <= ask_valid_nxt;
      bid_count    <= popcount(bid_valid_nxt);
      ask_count    <= popcount(ask_valid_nxt);
      match_signal <= do_fill;
      reject       <= do_reject;
      if (do_fill) begin
        match_price <= best_price;
        match_qty   <= fill_qty;
      end
    end
  end

  // slot payload; only meaningful while the matching valid bit is set, so it carries no reset
  always_ff @(posedge slow_clk) begin
    if (do_fill) begin
      if (work_side) bid_qty[best_idx] <= best_qty - fill_qty;
      else           ask_qty[best_idx] <= best_qty - fill_qty;
    end
    if (do_rest) begin
      if (work_side) begin
        ask_price[free_idx] <= work_price;
        ask_qty[free_idx]   <= work_qty;
      end else begin
        bid_price[free_idx] <= work_price;
        bid_qty[free_idx]   <= work_qty;
      end
    end
  end

endmodule

// File: tb/tb_order_matcher.sv
// tb/tb_order_matcher.sv - directed and randomized checks of order_matcher against a book model
module tb_order_matcher;

  localparam int D  = 4;
  localparam int PW = 8;
  localparam int QW = 8;
  localparam int CW = $clog2(D + 1);

  logic          slow_clk = 1'b0;
  logic          reset;
  logic          halt;
  logic          order_valid;
  logic          order_side;
  logic [PW-1:0] order_price;
  logic [QW-1:0] order_qty;
  logic          order_ready;
  logic          match_signal;
  logic [PW-1:0] match_price;
  logic [QW-1:0] match_qty;
  logic          reject;
  logic [CW-1:0] bid_count;
  logic [CW-1:0] ask_count;

  order_matcher #(.DEPTH(D), .PW(PW), .QW(QW)) dut (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .halt         (halt),
    .order_valid  (order_valid),
    .order_side   (order_side),
    .order_price  (order_price),
    .order_qty    (order_qty),
    .order_ready  (order_ready),
    .match_signal (match_signal),
    .match_price  (match_price),
    .match_qty    (match_qty),
    .reject       (reject),
    .bid_count    (bid_count),
    .ask_count    (ask_count)
  );

  always #5 slow_clk = ~slow_clk;

  int checks = 0;
  int errors = 0;

  // model book: index 0 = bids, 1 = asks
  int bk_v [2][D];
  int bk_p [2][D];
  int bk_q [2][D];
  // one entry per decide: kind 0 = quiet, 1 = fill, 2 = reject
  int exp_kind [$];
  int exp_p    [$];
  int exp_q    [$];
  int last_p = 0;
  int last_q = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < D; i++) begin
        bk_v[s][i] = 0; bk_p[s][i] = 0; bk_q[s][i] = 0;
      end
    last_p = 0;
    last_q = 0;
  endtask

  function automatic int model_count(input int s);
    int n = 0;
    for (int i = 0; i < D; i++) n += bk_v[s][i];
    return n;
  endfunction

  // apply one order to the model book, listing what each decide should emit
  task automatic model_order(input int side, input int price, input int qty);
    int rem, opp, best, f, slot;
    exp_kind.delete(); exp_p.delete(); exp_q.delete();
    rem = qty;
    opp = 1 - side;
    if (rem == 0) begin
      exp_kind.push_back(0); exp_p.push_back(0); exp_q.push_back(0);
    end
    while (rem > 0) begin
      best = -1;
      for (int i = 0; i < D; i++) begin
        if (bk_v[opp][i] != 0 &&
            ((side == 0 && bk_p[opp][i] <= price) || (side == 1 && bk_p[opp][i] >= price))) begin
          if (best < 0 ||
              (side == 0 && bk_p[opp][i] < bk_p[opp][best]) ||
              (side == 1 && bk_p[opp][i] > bk_p[opp][best]))
            best = i;
        end
      end
      if (best >= 0) begin
        f = (rem < bk_q[opp][best]) ? rem : bk_q[opp][best];
        exp_kind.push_back(1); exp_p.push_back(bk_p[opp][best]); exp_q.push_back(f);
        bk_q[opp][best] -= f;
        if (bk_q[opp][best] == 0) bk_v[opp][best] = 0;
        rem -= f;
      end else begin
        slot = -1;
        for (int i = D - 1; i >= 0; i--) if (bk_v[side][i] == 0) slot = i;
        if (slot >= 0) begin
          bk_v[side][slot] = 1; bk_p[side][slot] = price; bk_q[side][slot] = rem;
          exp_kind.push_back(0);
        end else begin
          exp_kind.push_back(2);
        end
        exp_p.push_back(0); exp_q.push_back(0);
        rem = 0;
      end
    end
  endtask

  // present one order (optionally halted first, or halt raised mid-flight) and check every cycle
  task automatic run_order(input int side, input int price, input int qty,
                           input int halt_pre, input int halt_mid_at);
    int n, total, m, pre_bid, pre_ask, em, er;
    pre_bid = model_count(0);
    pre_ask = model_count(1);
    model_order(side, price, qty);
    n = exp_kind.size();
    total = n * (D + 1);
    @(negedge slow_clk);
    order_valid = 1'b1;
    order_side  = side[0];
    order_price = PW'(price);
    order_qty   = QW'(qty);
    if (halt_pre > 0) begin
      halt = 1'b1;
      repeat (halt_pre) begin
        @(negedge slow_clk);
        check("halt_ready", order_ready, 0);
        check("halt_bid_count", bid_count, pre_bid);
        check("halt_ask_count", ask_count, pre_ask);
        check("halt_match", match_signal, 0);
      end
      halt = 1'b0;
    end
    #1;
    check("ready_idle", order_ready, 1);
    @(posedge slow_clk);
    @(negedge slow_clk);
    order_valid = 1'b0;
    check("ready_busy", order_ready, 0);
    for (int k = 1; k <= total; k++) begin
      @(negedge slow_clk);
      em = 0;
      er = 0;
      if (k % (D + 1) == 0) begin
        m = k / (D + 1) - 1;
        em = (exp_kind[m] == 1) ? 1 : 0;
        er = (exp_kind[m] == 2) ? 1 : 0;
        if (em != 0) begin
          last_p = exp_p[m];
          last_q = exp_q[m];
        end
      end
      check("match_signal", match_signal, em);
      check("reject", reject, er);
      check("match_price", match_price, last_p);
      check("match_qty", match_qty, last_q);
      check("order_ready", order_ready, (k == total) ? {31'd0, !halt} : 0);
      if (k == halt_mid_at) halt = 1'b1;
    end
    check("bid_count", bid_count, model_count(0));
    check("ask_count", ask_count, model_count(1));
    halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge slow_clk);
    reset = 1'b1;
    order_valid = 1'b0;
    halt = 1'b0;
    #1;
    check("rst_match", match_signal, 0);
    check("rst_reject", reject, 0);
    check("rst_price", match_price, 0);
    check("rst_qty", match_qty, 0);
    check("rst_bid_count", bid_count, 0);
    check("rst_ask_count", ask_count, 0);
    check("rst_ready", order_ready, 1);
    @(negedge slow_clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    halt = 1'b0;
    order_valid = 1'b0;
    order_side = 1'b0;
    order_price = '0;
    order_qty = '0;
    model_clear();
    #1;
    check("init_match", match_signal, 0);
    check("init_reject", reject, 0);
    check("init_bid_count", bid_count, 0);
    check("init_ask_count", ask_count, 0);
    check("init_ready", order_ready, 1);
    @(negedge slow_clk);
    reset = 1'b0;

    // single fill, then consume the 6 left resting and rest the buy remainder
    run_order(1, 50, 10, 0, 0);
    check("single_ask_count", ask_count, 1);
    run_order(0, 55, 4, 0, 0);
    check("single_price", match_price, 50);
    check("single_qty", match_qty, 4);
    run_order(0, 50, 10, 0, 0);
    check("rest_left_qty", match_qty, 6);
    check("rest_bid_count", bid_count, 1);

    // multi-fill sweep takes the cheaper ask first
    do_reset();
    run_order(1, 42, 3, 0, 0);
    run_order(1, 40, 3, 0, 0);
    run_order(0, 45, 5, 0, 0);
    check("sweep_price", match_price, 42);
    check("sweep_qty", match_qty, 2);
    check("sweep_ask_count", ask_count, 1);
    check("sweep_bid_count", bid_count, 0);
    run_order(0, 42, 1, 0, 0);
    check("sweep_left_qty", match_qty, 1);

    // book full rejects
    do_reset();
    for (int p = 10; p <= 13; p++) run_order(0, p, 1, 0, 0);
    run_order(0, 9, 2, 0, 0);
    check("full_bid_count", bid_count, 4);

    // halt gates acceptance only
    do_reset();
    run_order(1, 60, 5, 0, 0);
    run_order(0, 70, 2, 20, 0);
    run_order(0, 70, 2, 0, 2);
    check("halt_mid_qty", match_qty, 2);

    // equal-price asks: lowest slot wins, second untouched
    do_reset();
    run_order(1, 30, 2, 0, 0);
    run_order(1, 30, 2, 0, 0);
    run_order(0, 30, 2, 0, 0);
    check("tie_ask_count", ask_count, 1);
    run_order(0, 30, 2, 0, 0);
    check("tie_second_qty", match_qty, 2);
    run_order(1, 30, 0, 0, 0);

    // reset during scan drops the order and the book
    run_order(1, 20, 5, 0, 0);
    @(negedge slow_clk);
    order_valid = 1'b1; order_side = 1'b0; order_price = 8'd25; order_qty = 8'd5;
    @(posedge slow_clk);
    @(negedge slow_clk);
    order_valid = 1'b0;
    @(negedge slow_clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ask_count", ask_count, 0);
    check("mid_rst_ready", order_ready, 1);
    check("mid_rst_price", match_price, 0);
    @(negedge slow_clk);
    reset = 1'b0;
    model_clear();
    repeat (12) begin
      @(negedge slow_clk);
      check("post_rst_match", match_signal, 0);
      check("post_rst_reject", reject, 0);
      check("post_rst_counts", {bid_count, ask_count}, 0);
    end

    // randomized orders against the model
    for (int t = 0; t < 60; t++) begin
      int rs, rp, rq, hm;
      rs = $urandom_range(0, 1);
      rp = $urandom_range(20, 28);
      rq = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      hm = ($urandom_range(0, 7) == 0) ? 3 : 0;
      run_order(rs, rp, rq, 0, hm);
      if (t == 30) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/order_matcher.md
# order_matcher

Single-order-at-a-time price-crossing engine that sits directly upstream of the trade counter. It accepts buy/sell orders over a valid/ready handshake and holds up to DEPTH resting orders per side. Each incoming order is matched against the best crossing opposite-side order. Every fill emits a one-cycle `match_signal` with price and quantity; this pulse drives the counter's `enable_count`, and the counter's `halt_signal` feeds back into `halt`.

## Interface
- `DEPTH`, 4: resting-order slots per side (≥1).
- `PW`, 8: price width.
- `QW`, 8: quantity width.

- `slow_clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `halt`  in  1  when high, no new order accepted; from counter `halt_signal`.
- `order_valid`  in  1  order present on `order_*`.
- `order_side`  in  1  0 = buy, 1 = sell.
- `order_price`  in  PW  limit price, unsigned.
- `order_qty`  in  QW  quantity, unsigned.
- `order_ready`  out  1  high only in IDLE with `halt` low.
- `match_signal`  out  1  one-cycle pulse per fill.
- `match_price`  out  PW  resting order's price for the fill; held until next fill.
- `match_qty`  out  QW  filled quantity; held until next fill.
- `reject`  out  1  one-cycle pulse: unfilled remainder dropped, own side full.
- `bid_count`  out  $clog2(DEPTH+1)  valid bid slots.
- `ask_count`  out  $clog2(DEPTH+1)  valid ask slots.

## Operation
- Book: per side, DEPTH slots of {valid, price, qty}. Reset clears all valid bits.
- States: IDLE, SCAN, DECIDE.
- IDLE:
  - Accept on `order_valid && order_ready`.
  - Latch side, price, qty into working registers; clear best-candidate registers; go to SCAN with index 0.
- SCAN: examines one opposite-side slot per cycle, index 0..DEPTH-1, then goes to DECIDE.
  - Incoming buy: a slot crosses if valid and ask price ≤ order price. Best = lowest price.
  - Incoming sell: a slot crosses if valid and bid price ≥ order price. Best = highest price.
  - Ties: lowest index wins (strict compare on update).
- DECIDE, exactly one cycle, one of four outcomes:
  - Working qty = 0: go to IDLE, no output.
  - Crossing slot found:
    - Fill = min(working qty, slot qty).
    - Register `match_signal`=1, `match_price`=slot price, `match_qty`=fill.
    - Subtract fill from both working qty and slot qty; slot qty reaching 0 clears its valid bit.
    - Remaining working qty > 0: go back to SCAN at index 0. Otherwise go to IDLE.
  - No cross, free own-side slot exists: write remainder into lowest-index free slot; go to IDLE.
  - No cross, own side full: pulse `reject`, drop remainder; go to IDLE.
- Arithmetic:
  - Fill never exceeds either operand, so there is no underflow.
  - Counts are the population count of valid bits, registered and updated on the same edge as the slot change.
- Halt:
  - Gates acceptance only.
  - An order already past IDLE completes every fill and rest normally.
  - Halt rising during SCAN does not abort.
- Zero-qty order: accepted and scanned; DECIDE sends it to IDLE with no match, rest or reject.

## Timing
- Reset values:
  - State IDLE, all slots invalid.
  - `match_signal`, `reject`, `match_price`, `match_qty`, `bid_count`, `ask_count` = 0.
  - `order_ready` = !halt.
- Reset mid-operation discards the in-flight order and the whole book; no pulse follows.
- Accept at edge 0:
  - SCAN occupies edges 1..DEPTH; DECIDE acts at edge DEPTH+1.
  - With DEPTH=4, `match_signal` or `reject` is high from edge 5 to edge 6.
- Each additional fill for the same order costs DEPTH+1 more cycles. Consecutive `match_signal` pulses are therefore DEPTH+1 cycles apart and are never back-to-back.
- After the final DECIDE, `order_ready` rises in the same cycle as the last pulse (edge DEPTH+1).
- `order_ready` is low throughout SCAN and DECIDE. An order held on the inputs waits; valid may stay high.

## Test plan
- **Reset:** assert `reset` mid-stream → all outputs 0, `order_ready`=1, counts 0, and no pulse follows.
- **Single fill:** sell 10@50, then buy 4@55 →
  - After the sell: `ask_count`=1, no match.
  - After the buy: one `match_signal` at edge 5 after accept, with `match_price`=50, `match_qty`=4.
  - Resting ask qty 6; `order_ready` high at edge 5.
- **Multi-fill sweep:** asks 3@42 (slot 0) and 3@40 (slot 1), then buy 5@45 →
  - Pulse (40,3), then pulse (42,2) five cycles later.
  - `ask_count`=1, remaining ask 1@42, `bid_count`=0.
- **Book full:** bids rest at 10, 11, 12, 13 with no asks; a fifth bid 2@9 → `reject` pulse at edge 5, `bid_count` stays 4.
- **Halt:** `halt`=1 with `order_valid` held → `order_ready`=0 and nothing accepted for 20 cycles. Drop `halt` → accept in the next cycle. `halt` rising during SCAN still yields the pending match pulse.
- **Price tie and equality:** asks 2@30 in slot 0 and slot 1, then buy 2@30 → a single fill (30,2) from slot 0; slot 1 untouched; `ask_count`=1.
